// File: rtl/axis_threshold_detector_if.sv
// axis_threshold_detector_if: AXI4-Stream data/valid/ready bundle
interface axis_threshold_detector_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_threshold_detector.sv
// axis_threshold_detector: signed sample-vs-threshold trigger with holdoff and wrapping trigger count
module axis_threshold_detector #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [CNTR_WIDTH-1:0]        cfg_holdoff,
    axis_threshold_detector_if.slave     s_axis,
    axis_threshold_detector_if.slave     s_thr,
    output logic                         state_data,
    output logic                         trigger,
    output logic [CNTR_WIDTH-1:0]        trg_count
);
    typedef enum logic [1:0] {ARMED = 2'b00, TRIGGERED = 2'b01, HOLDOFF = 2'b10} state_t;
    state_t                state, state_n;
    logic [CNTR_WIDTH-1:0] cnt, cnt_n;
    logic signed [15:0]    thr;
    logic                  sample_ok, above, fire;
    assign s_axis.tready = !areset;
    assign s_thr.tready  = !areset;
    assign sample_ok     = s_axis.tvalid && s_axis.tready;
    // threshold register holds the previous value during a same-cycle write
    assign above         = $signed(s_axis.tdata[15:0]) > thr;
    always_comb begin
        state_n = ARMED;
        cnt_n   = cnt;
        fire    = 1'b0;
        case (state)
            ARMED: begin
                fire    = sample_ok && above;
                state_n = fire ? TRIGGERED : ARMED;
            end
            TRIGGERED: begin
                state_n = (sample_ok && !above) ? HOLDOFF : TRIGGERED;
                cnt_n   = (sample_ok && !above) ? cfg_holdoff : cnt;
            end
            HOLDOFF: begin
                state_n = (cnt == '0) ? ARMED : HOLDOFF;
                cnt_n   = (cnt == '0) ? '0 : cnt - CNTR_WIDTH'(1);
            end
            default: state_n = ARMED;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ARMED;
            cnt        <= '0;
            thr        <= 16'sh7FFF;
            state_data <= 1'b1;
            trigger    <= 1'b0;
            trg_count  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            if (s_thr.tvalid && s_thr.tready)
                thr <= s_thr.tdata[15:0];
            state_data <= (state_n == ARMED);
            trigger    <= fire;
            trg_count  <= fire ? trg_count + CNTR_WIDTH'(1) : trg_count;
        end
    end
endmodule
